// File: rtl/doodle_physics.sv
// Vertical physics for the doodle: jump launch, gravity, platform/floor landing and death.
// All position/velocity updates happen only on frame_tick; launches raise jump_pulse for one cycle.
module doodle_physics #(
  parameter int JUMP_V        = 20,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL_V    = 20,
  parameter int DOODLE_H      = 80,
  parameter int SCREEN_BOTTOM = 767,
  parameter int START_Y       = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              frame_tick,
  input  logic [1:0][9:0]   ground,
  output logic [9:0]        doodle_y,
  output logic signed [7:0] velocity,
  output logic [1:0]        state,
  output logic              jump_pulse,
  output logic              dead
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RISING  = 2'b01,
    S_FALLING = 2'b10,
    S_DEAD    = 2'b11
  } state_t;

  localparam logic signed [11:0] H_S      = 12'(DOODLE_H);
  localparam logic signed [11:0] G_S      = 12'(GRAVITY);
  localparam logic signed [11:0] BOTTOM_S = 12'(SCREEN_BOTTOM);
  localparam logic signed [11:0] MAXV_S   = 12'(MAX_FALL_V);
  localparam logic signed [7:0]  V_LAUNCH = 8'(-JUMP_V);
  localparam logic signed [7:0]  V_MAX    = 8'(MAX_FALL_V);
  localparam logic [9:0]         Y_START  = 10'(START_Y);

  state_t             state_q, state_d;
  logic [9:0]         doodle_y_q, doodle_y_d;
  logic signed [7:0]  velocity_q, velocity_d;
  logic               floor_en_q, floor_en_d;
  logic               jump_pulse_q, jump_pulse_d;

  logic signed [11:0] y_s, v_s, y_next_s, foot_s, foot_next_s, gnd_s, v_inc_s;
  logic               gnd_is_floor, landing, fall_off;
  logic               ground_x_unused;

  // Horizontal position is consumed by the collision stage only.
  assign ground_x_unused = ^ground[1];

  assign y_s          = {2'b00, doodle_y_q};
  assign v_s          = {{4{velocity_q[7]}}, velocity_q};
  assign y_next_s     = y_s + v_s;
  assign foot_s       = y_s + H_S;
  assign foot_next_s  = y_next_s + H_S;
  assign gnd_s        = {2'b00, ground[0]};
  assign v_inc_s      = v_s + G_S;
  assign gnd_is_floor = (gnd_s == BOTTOM_S);
  assign landing      = (!gnd_is_floor || floor_en_q) && (foot_s <= gnd_s) && (foot_next_s >= gnd_s);
  assign fall_off     = !floor_en_q && (foot_next_s > BOTTOM_S);

  function automatic logic [9:0] clamp_y(input logic signed [11:0] val);
    if (val < 12'sd0)
      return 10'd0;
    else if (val > BOTTOM_S)
      return BOTTOM_S[9:0];
    else
      return val[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      doodle_y_q   <= Y_START;
      velocity_q   <= 8'sd0;
      floor_en_q   <= 1'b1;
      jump_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      doodle_y_q   <= doodle_y_d;
      velocity_q   <= velocity_d;
      floor_en_q   <= floor_en_d;
      jump_pulse_q <= jump_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_RISING;
      S_RISING:  if (frame_tick && v_inc_s >= 12'sd0) state_d = S_FALLING;
      S_FALLING: begin
        if (frame_tick) begin
          if (landing)       state_d = S_RISING;
          else if (fall_off) state_d = S_DEAD;
        end
      end
      default:   state_d = S_DEAD;
    endcase
  end

  always_comb begin
    doodle_y_d   = doodle_y_q;
    velocity_d   = velocity_q;
    floor_en_d   = floor_en_q;
    jump_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start wins over a coincident frame_tick: no position update this cycle.
        if (start) begin
          velocity_d   = V_LAUNCH;
          jump_pulse_d = 1'b1;
        end
      end
      S_RISING: begin
        if (frame_tick) begin
          doodle_y_d = clamp_y(y_next_s);
          velocity_d = v_inc_s[7:0];
        end
      end
      S_FALLING: begin
        if (frame_tick) begin
          if (landing) begin
            doodle_y_d   = clamp_y(gnd_s - H_S);
            velocity_d   = V_LAUNCH;
            jump_pulse_d = 1'b1;
            if (!gnd_is_floor) floor_en_d = 1'b0;
          end else if (!fall_off) begin
            doodle_y_d = clamp_y(y_next_s);
            velocity_d = (v_inc_s > MAXV_S) ? V_MAX : v_inc_s[7:0];
          end
        end
      end
      default: ;
    endcase
  end

  assign doodle_y   = doodle_y_q;
  assign velocity   = velocity_q;
  assign state      = state_q;
  assign jump_pulse = jump_pulse_q;
  assign dead       = (state_q == S_DEAD);

endmodule

// File: tb/tb_doodle_physics.sv
// Directed vector table plus randomized run against an integer reference model of doodle_physics.
module tb_doodle_physics;

  logic              clk = 1'b0;
  logic              rst, start, frame_tick;
  logic [1:0][9:0]   ground;
  logic [9:0]        doodle_y;
  logic signed [7:0] velocity;
  logic [1:0]        state;
  logic              jump_pulse, dead;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  doodle_physics dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_tick (frame_tick),
    .ground     (ground),
    .doodle_y   (doodle_y),
    .velocity   (velocity),
    .state      (state),
    .jump_pulse (jump_pulse),
    .dead       (dead)
  );

  typedef struct {
    logic rst;
    logic start;
    logic tick;
    int   gnd;
    int   reps;
    int   exp_y;
    int   exp_v;
    int   exp_st;
    logic exp_pulse;
  } vec_t;

  vec_t vecs[26];

  // Reference model state (plain integers).
  int m_y, m_v, m_st, m_fe, m_p;

  task automatic check_out(input string name, input int ey, input int ev, input int est, input int ep);
    int ay, av, ast, ap, ad, ed;
    ay  = int'(doodle_y);
    av  = int'(velocity);
    ast = int'(state);
    ap  = int'(jump_pulse);
    ad  = int'(dead);
    ed  = (est == 3) ? 1 : 0;
    tests++;
    if (ay != ey || av != ev || ast != est || ap != ep || ad != ed) begin
      fails++;
      $display("FAIL %s: got y=%0d v=%0d st=%0d pulse=%0d dead=%0d, want y=%0d v=%0d st=%0d pulse=%0d dead=%0d",
               name, ay, av, ast, ap, ad, ey, ev, est, ep, ed);
    end
  endtask

  task automatic model_step(input int r, input int s, input int t, input int g);
    int yn;
    if (r != 0) begin
      m_y = 600; m_v = 0; m_st = 0; m_fe = 1; m_p = 0;
      return;
    end
    m_p = 0;
    if (m_st == 0) begin
      if (s != 0) begin m_v = -20; m_st = 1; m_p = 1; end
    end else if (m_st == 1) begin
      if (t != 0) begin
        yn  = m_y + m_v;
        m_y = (yn < 0) ? 0 : yn;
        m_v = m_v + 1;
        if (m_v >= 0) m_st = 2;
      end
    end else if (m_st == 2) begin
      if (t != 0) begin
        if ((g != 767 || m_fe != 0) && (m_y + 80 <= g) && (m_y + m_v + 80 >= g)) begin
          m_y  = (g - 80 > 767) ? 767 : g - 80;
          m_v  = -20;
          m_st = 1;
          m_p  = 1;
          if (g != 767) m_fe = 0;
        end else if (m_fe == 0 && m_y + m_v + 80 > 767) begin
          m_st = 3;
        end else begin
          m_y = (m_y + m_v > 767) ? 767 : m_y + m_v;
          m_v = (m_v + 1 > 20) ? 20 : m_v + 1;
        end
      end
    end
  endtask

  initial begin
    int g_sel, g_val, r_i, s_i, t_i;
    //             rst start tick gnd reps   y    v  st pulse
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 767,  1, 600,   0, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 767,  5, 600,   0, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 767,  1, 600, -20, 1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 767,  1, 600, -20, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 767,  1, 580, -19, 1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 767, 19, 390,   0, 2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 767,  5, 400,   5, 2, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 480,  1, 400, -20, 1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 100,  1, 400, -20, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 767, 20, 190,   0, 2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 767, 20, 380,  20, 2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 767, 15, 680,  20, 2, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 767,  1, 680,  20, 3, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 767,  3, 680,  20, 3, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 767,  1, 600,   0, 0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 767,  1, 600, -20, 1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 767,  3, 543, -17, 1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 767,  1, 600,   0, 0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 767,  1, 600, -20, 1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 767,  1, 600, -20, 1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 767, 20, 390,   0, 2, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 767, 25, 680,  20, 2, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 767,  1, 687, -20, 1, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 767, 20, 477,   0, 2, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 767, 20, 667,  20, 2, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b1, 767,  1, 687, -20, 1, 1'b1};

    rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
    ground[0] = 10'd767; ground[1] = 10'd0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        rst        = vecs[i].rst;
        start      = vecs[i].start;
        frame_tick = vecs[i].tick;
        ground[0]  = 10'(vecs[i].gnd);
        ground[1]  = 10'($urandom_range(0, 1023));
        @(posedge clk); #1;
      end
      check_out($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_v, vecs[i].exp_st, int'(vecs[i].exp_pulse));
      $display("[TB] vec %0d: y=%0d v=%0d st=%0d pulse=%0d dead=%0d",
               i, doodle_y, velocity, state, jump_pulse, dead);
    end

    // Randomized run; reset first so model and DUT start aligned.
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
    model_step(1, 0, 0, 767);
    @(posedge clk); #1;
    check_out("rand_reset", m_y, m_v, m_st, m_p);

    for (int c = 0; c < 4000; c++) begin
      r_i   = ($urandom_range(0, 299) == 0) ? 1 : 0;
      s_i   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      t_i   = ($urandom_range(0, 1) == 0) ? 1 : 0;
      g_sel = $urandom_range(0, 3);
      g_val = int'(ground[0]);
      if (g_sel == 0)      g_val = 767;
      else if (g_sel == 1) g_val = (m_y + 80 > 1023) ? 1023 : m_y + 80;
      else if (g_sel == 2) g_val = $urandom_range(80, 767);
      rst        = r_i[0];
      start      = s_i[0];
      frame_tick = t_i[0];
      ground[0]  = 10'(g_val);
      ground[1]  = 10'($urandom_range(0, 1023));
      model_step(r_i, s_i, t_i, g_val);
      @(posedge clk); #1;
      check_out($sformatf("rand%0d", c), m_y, m_v, m_st, m_p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
